// File: rtl/conv_result_streamer_if.sv
// Handshake bundle between a conv-layer result producer and a pixel consumer.
// Ports: frame/frame_valid/frame_ready (whole-frame capture handshake),
//        pix_data/pix_row/pix_col/pix_last/pix_valid/pix_ready (pixel stream), frame_count.
interface conv_result_streamer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OH         = 28,
  parameter int OW         = 28
);
  // Pixel k occupies frame[k*DATA_WIDTH +: DATA_WIDTH], k = row*OW + col.
  logic [0:OH*OW*DATA_WIDTH-1] frame;
  logic                        frame_valid;
  logic                        frame_ready;
  logic [DATA_WIDTH-1:0]       pix_data;
  logic                        pix_valid;
  logic                        pix_ready;
  logic [5:0]                  pix_row;
  logic [5:0]                  pix_col;
  logic                        pix_last;
  logic [7:0]                  frame_count;

  // master: the streamer itself
  modport master (
    input  frame, frame_valid, pix_ready,
    output frame_ready, pix_data, pix_valid, pix_row, pix_col, pix_last, frame_count
  );

  // slave: the environment that supplies frames and sinks pixels
  modport slave (
    output frame, frame_valid, pix_ready,
    input  frame_ready, pix_data, pix_valid, pix_row, pix_col, pix_last, frame_count
  );
endinterface

// File: rtl/conv_result_streamer.sv
// Captures a whole flat conv-layer result and streams it out one pixel per cycle in raster order.
// Ports: clk, reset (sync, active-low), bus (master modport: frame capture in, pixel stream out).
// Latency: first pixel valid the cycle after capture; stalls hold the pixel stable while pix_ready=0.
module conv_result_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int OH         = 28,
  parameter int OW         = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  conv_result_streamer_if.master bus
);

  localparam int NPIX = OH * OW;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int BW   = (NPIX * DATA_WIDTH > 1) ? $clog2(NPIX * DATA_WIDTH) : 1;
  localparam logic [5:0] LAST_ROW = 6'(OH - 1);
  localparam logic [5:0] LAST_COL = 6'(OW - 1);
  localparam logic       SINGLE   = (OH == 1) && (OW == 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                      state_q, state_d;
  logic [0:NPIX*DATA_WIDTH-1]  frame_buf;
  logic [5:0]                  row_q, col_q, row_nxt, col_nxt;
  logic [IW-1:0]               idx_q, idx_nxt;
  logic [BW-1:0]               rd_base;
  logic [DATA_WIDTH-1:0]       pix_data_q;
  logic                        pix_last_q;
  logic [7:0]                  frame_count_q;
  logic                        capture, xfer;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the capture/transfer strobes that steer the datapath
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_valid) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // frame_valid is deliberately not looked at here, so a frame offered
        // alongside the final transfer is taken on the following IDLE cycle.
        if (bus.pix_ready) begin
          xfer = 1'b1;
          if (pix_last_q) state_d = IDLE;
        end
      end
    endcase
  end

  // Raster advance; a linear index runs alongside row/col to avoid a multiply
  // when addressing the buffer.
  always_comb begin
    row_nxt = row_q;
    col_nxt = col_q + 6'd1;
    if (col_q == LAST_COL) begin
      col_nxt = 6'd0;
      row_nxt = row_q + 6'd1;
    end
  end

  assign idx_nxt = idx_q + IW'(1);
  assign rd_base = BW'(32'(idx_nxt) * DATA_WIDTH);

  // Frame buffer is pure storage: its content is don't-care until a capture.
  always_ff @(posedge clk) begin
    if (capture) frame_buf <= bus.frame;
  end

  // Output pixel is registered and preloaded one pixel ahead, so a stall
  // simply holds the registers and streaming needs no bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q         <= 6'd0;
      col_q         <= 6'd0;
      idx_q         <= '0;
      pix_data_q    <= '0;
      pix_last_q    <= 1'b0;
      frame_count_q <= 8'd0;
    end else if (capture) begin
      row_q      <= 6'd0;
      col_q      <= 6'd0;
      idx_q      <= '0;
      pix_data_q <= bus.frame[0 +: DATA_WIDTH];
      pix_last_q <= SINGLE;
    end else if (xfer) begin
      if (pix_last_q) begin
        frame_count_q <= frame_count_q + 8'd1;
      end else begin
        row_q      <= row_nxt;
        col_q      <= col_nxt;
        idx_q      <= idx_nxt;
        pix_data_q <= frame_buf[rd_base +: DATA_WIDTH];
        pix_last_q <= (row_nxt == LAST_ROW) && (col_nxt == LAST_COL);
      end
    end
  end

  assign bus.frame_ready = (state_q == IDLE);
  assign bus.pix_valid   = (state_q == STREAM);
  assign bus.pix_data    = pix_data_q;
  assign bus.pix_row     = row_q;
  assign bus.pix_col     = col_q;
  assign bus.pix_last    = pix_last_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Bench for conv_result_streamer: three instances (2x3, default 28x28, 1x1) driven with
// random frames and checked against a raster-order model computed from pixel index k.
// Ports: none (top-level bench).
module tb_conv_result_streamer;

  localparam int DW  = 16;
  localparam int N0  = 6;     // 2x3
  localparam int OW1 = 28;
  localparam int N1  = 784;   // 28x28

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DW-1:0] e0[N0];
  logic [DW-1:0] e1[N1];

  conv_result_streamer_if #(.DATA_WIDTH(DW), .OH(2),  .OW(3))  i0 ();
  conv_result_streamer_if #(.DATA_WIDTH(DW), .OH(28), .OW(28)) i1 ();
  conv_result_streamer_if #(.DATA_WIDTH(DW), .OH(1),  .OW(1))  i2 ();

  conv_result_streamer #(.DATA_WIDTH(DW), .OH(2),  .OW(3))  d0 (.clk(clk), .reset(rst0), .bus(i0));
  conv_result_streamer #(.DATA_WIDTH(DW), .OH(28), .OW(28)) d1 (.clk(clk), .reset(rst1), .bus(i1));
  conv_result_streamer #(.DATA_WIDTH(DW), .OH(1),  .OW(1))  d2 (.clk(clk), .reset(rst2), .bus(i2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {frame_ready, pix_valid, pix_last, pix_data, pix_row, pix_col, frame_count}
  localparam logic [38:0] RST_VEC = {1'b1, 1'b0, 1'b0, 16'h0, 6'd0, 6'd0, 8'd0};

  task automatic test_reset();
    logic [38:0] got;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    i0.frame_valid = 1'b1; i1.frame_valid = 1'b1; i2.frame_valid = 1'b1;
    step(); step();
    got = {i0.frame_ready, i0.pix_valid, i0.pix_last, i0.pix_data, i0.pix_row, i0.pix_col, i0.frame_count};
    n_checks++; if (got !== RST_VEC) begin n_fail++; $display("FAIL reset_d0: got %h expected %h", got, RST_VEC); end
    got = {i1.frame_ready, i1.pix_valid, i1.pix_last, i1.pix_data, i1.pix_row, i1.pix_col, i1.frame_count};
    n_checks++; if (got !== RST_VEC) begin n_fail++; $display("FAIL reset_d1: got %h expected %h", got, RST_VEC); end
    got = {i2.frame_ready, i2.pix_valid, i2.pix_last, i2.pix_data, i2.pix_row, i2.pix_col, i2.frame_count};
    n_checks++; if (got !== RST_VEC) begin n_fail++; $display("FAIL reset_d2: got %h expected %h", got, RST_VEC); end
    // frame_valid seen only during reset must not have been captured
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    i0.frame_valid = 1'b0; i1.frame_valid = 1'b0; i2.frame_valid = 1'b0;
    step();
    got = {36'd0, i0.pix_valid, i1.pix_valid, i2.pix_valid};
    n_checks++; if (got !== 39'd0) begin n_fail++; $display("FAIL reset_no_capture: got valids %b expected 000", got[2:0]); end
  endtask

  task automatic test_basic();
    logic [30:0] got, exp;
    for (int k = 0; k < N0; k++) begin
      e0[k] = DW'(k + 1);
      i0.frame[k*DW +: DW] = e0[k];
    end
    i0.pix_ready = 1'b1;
    i0.frame_valid = 1'b1;
    step();
    i0.frame_valid = 1'b0;
    for (int k = 0; k < N0; k++) begin
      got = {i0.pix_valid, i0.frame_ready, i0.pix_data, i0.pix_row, i0.pix_col, i0.pix_last};
      exp = {1'b1, 1'b0, e0[k], 6'(k / 3), 6'(k % 3), (k == N0 - 1)};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL basic_px%0d: got %h expected %h", k, got, exp); end
      step();
    end
    got = {21'd0, i0.pix_valid, i0.frame_ready, i0.frame_count};
    exp = {21'd0, 1'b0, 1'b1, 8'd1};
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL basic_end: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ea[N0], eb[N0];
    logic [0:N0*DW-1] fa, fb;
    logic [30:0] got, exp;
    rst0 = 1'b0; step(); rst0 = 1'b1;
    for (int k = 0; k < N0; k++) begin
      ea[k] = DW'($urandom); eb[k] = DW'($urandom);
      fa[k*DW +: DW] = ea[k]; fb[k*DW +: DW] = eb[k];
    end
    i0.frame = fa; i0.frame_valid = 1'b1; i0.pix_ready = 1'b1;
    step();
    i0.frame = fb;  // frame_valid stays high through the whole first stream
    for (int k = 0; k < N0; k++) begin
      got = {i0.pix_valid, i0.frame_ready, i0.pix_data, i0.pix_row, i0.pix_col, i0.pix_last};
      exp = {1'b1, 1'b0, ea[k], 6'(k / 3), 6'(k % 3), (k == N0 - 1)};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_a_px%0d: got %h expected %h", k, got, exp); end
      step();
    end
    got = {21'd0, i0.pix_valid, i0.frame_ready, i0.frame_count};
    exp = {21'd0, 1'b0, 1'b1, 8'd1};
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_gap: got %h expected %h", got, exp); end
    step();
    i0.frame_valid = 1'b0;
    for (int k = 0; k < N0; k++) begin
      got = {i0.pix_valid, i0.frame_ready, i0.pix_data, i0.pix_row, i0.pix_col, i0.pix_last};
      exp = {1'b1, 1'b0, eb[k], 6'(k / 3), 6'(k % 3), (k == N0 - 1)};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_b_px%0d: got %h expected %h", k, got, exp); end
      step();
    end
    got = {21'd0, i0.pix_valid, i0.frame_ready, i0.frame_count};
    exp = {21'd0, 1'b0, 1'b1, 8'd2};
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_end: got %h expected %h", got, exp); end
  endtask

  // Backpressure 1,0,0,1 on the full-size map, with frame overwritten and
  // frame_valid held high after capture.
  task automatic test_backpressure_isolation();
    logic [30:0] got, exp;
    int k, cyc;
    for (int j = 0; j < N1; j++) begin
      e1[j] = DW'($urandom);
      i1.frame[j*DW +: DW] = e1[j];
    end
    i1.pix_ready = 1'b0;
    i1.frame_valid = 1'b1;
    step();
    i1.frame = '1;
    k = 0; cyc = 0;
    while (k < N1 && cyc < 4 * N1) begin
      i1.pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      got = {i1.pix_valid, i1.frame_ready, i1.pix_data, i1.pix_row, i1.pix_col, i1.pix_last};
      exp = {1'b1, 1'b0, e1[k], 6'(k / OW1), 6'(k % OW1), (k == N1 - 1)};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL bp_px%0d_cyc%0d: got %h expected %h", k, cyc, got, exp); end
      if (i1.pix_ready) k++;
      cyc++;
      step();
    end
    n_checks++; if (k != N1) begin n_fail++; $display("FAIL bp_timeout: delivered %0d expected %0d", k, N1); end
    got = {21'd0, i1.pix_valid, i1.frame_ready, i1.frame_count};
    exp = {21'd0, 1'b0, 1'b1, 8'd1};
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL bp_end: got %h expected %h", got, exp); end
    i1.frame_valid = 1'b0;
    step();
    n_checks++; if (i1.pix_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got pix_valid %b expected 0", i1.pix_valid); end
  endtask

  task automatic test_reset_midstream();
    logic [30:0] got, exp;
    logic [38:0] rgot;
    int xf, cyc;
    for (int j = 0; j < N1; j++) begin
      e1[j] = DW'($urandom);
      i1.frame[j*DW +: DW] = e1[j];
    end
    i1.frame_valid = 1'b1;
    step();
    i1.frame_valid = 1'b0;
    xf = 0; cyc = 0;
    while (xf < 100 && cyc < 1000) begin
      i1.pix_ready = 1'($urandom_range(0, 1));
      got = {i1.pix_valid, i1.frame_ready, i1.pix_data, i1.pix_row, i1.pix_col, i1.pix_last};
      exp = {1'b1, 1'b0, e1[xf], 6'(xf / OW1), 6'(xf % OW1), 1'b0};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL mid_px%0d: got %h expected %h", xf, got, exp); end
      if (i1.pix_ready) xf++;
      cyc++;
      step();
    end
    n_checks++; if (xf != 100) begin n_fail++; $display("FAIL mid_timeout: transfers %0d expected 100", xf); end
    rst1 = 1'b0;
    i1.pix_ready = 1'b1;
    step();
    rgot = {i1.frame_ready, i1.pix_valid, i1.pix_last, i1.pix_data, i1.pix_row, i1.pix_col, i1.frame_count};
    n_checks++; if (rgot !== RST_VEC) begin n_fail++; $display("FAIL mid_reset: got %h expected %h", rgot, RST_VEC); end
    rst1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++; if (i1.pix_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard_c%0d: got pix_valid %b expected 0", c, i1.pix_valid); end
    end
  endtask

  task automatic test_wrap();
    logic [30:0] got, exp;
    logic [DW-1:0] v;
    i2.pix_ready = 1'b1;  // ready while idle must be harmless
    for (int f = 0; f < 256; f++) begin
      v = DW'($urandom);
      i2.frame = v;
      i2.frame_valid = 1'b1;
      step();
      i2.frame_valid = 1'b0;
      got = {i2.pix_valid, i2.frame_ready, i2.pix_data, i2.pix_row, i2.pix_col, i2.pix_last};
      exp = {1'b1, 1'b0, v, 6'd0, 6'd0, 1'b1};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL wrap_px_f%0d: got %h expected %h", f, got, exp); end
      step();
      got = {22'd0, i2.pix_valid, i2.frame_count};
      exp = {22'd0, 1'b0, 8'(f + 1)};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL wrap_cnt_f%0d: got %h expected %h", f, got, exp); end
    end
    n_checks++; if (i2.frame_count !== 8'd0) begin n_fail++; $display("FAIL wrap_final: got %0d expected 0", i2.frame_count); end
  endtask

  initial begin
    i0.frame = '0; i1.frame = '0; i2.frame = '0;
    i0.frame_valid = 1'b0; i1.frame_valid = 1'b0; i2.frame_valid = 1'b0;
    i0.pix_ready = 1'b0; i1.pix_ready = 1'b0; i2.pix_ready = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure_isolation();
    test_reset_midstream();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_result_streamer.md
CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the pixel width in bits.
REQ-002 The block SHALL have parameter OH, default 28, giving the output-map height in pixels.
REQ-003 The block SHALL have parameter OW, default 28, giving the output-map width in pixels.
REQ-004 The block SHALL have one clock and reset, fixed as follows: reset is synchronous and active-low.
REQ-005 Port clk  input  1  rising-edge clock for all state.
REQ-006 Port reset  input  1  synchronous active-low reset; sampled on the clk rising edge, 0 = reset.
REQ-007 Port frame  input  [0:OH*OW*DATA_WIDTH-1]  flat conv-layer result; pixel k = frame[k*DATA_WIDTH +: DATA_WIDTH], k = row*OW+col.
REQ-008 Port frame_valid  input  1  frame holds a complete result.
REQ-009 Port frame_ready  output  1  block is idle and can capture a frame.
REQ-010 Port pix_data  output  DATA_WIDTH  current streamed pixel.
REQ-011 Port pix_valid  output  1  pix_data/pix_row/pix_col/pix_last are valid.
REQ-012 Port pix_ready  input  1  downstream accepts the pixel.
REQ-013 Port pix_row  output  6  row index of the current pixel.
REQ-014 Port pix_col  output  6  column index of the current pixel.
REQ-015 Port pix_last  output  1  current pixel is the final pixel of the frame, at (OH-1, OW-1).
REQ-016 Port frame_count  output  8  count of completed frames, wrapping.

Function
REQ-017 The FSM SHALL have two states: IDLE and STREAM.
REQ-018 In IDLE, frame_ready SHALL be 1 and pix_valid SHALL be 0; in STREAM, frame_ready SHALL be 0.
REQ-019 Capture: on a clock edge with frame_valid=1 and frame_ready=1, the block SHALL copy frame into an internal buffer, set row and col to 0, and enter STREAM.
REQ-020 Latency: pix_valid SHALL rise in the cycle after capture, presenting pixel 0 at (0,0).
REQ-021 Transfer occurs on a clock edge with pix_valid=1 and pix_ready=1; pix_data, pix_row, pix_col and pix_last SHALL remain stable while pix_valid=1 and pix_ready=0.
REQ-022 Index advance on each non-final transfer:
- col SHALL increment.
- At col=OW-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 Streamed pixels SHALL be presented without bubbles: with pix_ready held at 1, exactly one pixel SHALL transfer per cycle.
REQ-024 pix_last SHALL be 1 exactly when row=OH-1 and col=OW-1.
REQ-025 On the transfer with pix_last=1:
- The block SHALL return to IDLE.
- pix_valid SHALL be 0 in the next cycle.
- frame_count SHALL increment modulo 256.
REQ-026 frame_valid asserted during STREAM SHALL be ignored; frame SHALL NOT be re-sampled, and the buffer SHALL be immune to changes on frame.
REQ-027 When the final transfer and frame_valid=1 occur in the same cycle, the new frame SHALL NOT be captured in that cycle; capture SHALL occur in the following IDLE cycle.
REQ-028 pix_ready=1 while pix_valid=0 SHALL have no effect.
REQ-029 OH and OW SHALL each be in the range 1 to 63; OH=OW=1 SHALL produce a single pixel with pix_last=1.

Reset
REQ-030 When reset=0 at a clock edge, the block SHALL load the following values regardless of state, including mid-stream:
- state = IDLE
- frame_ready = 1
- pix_valid = 0
- pix_last = 0
- pix_data = 0
- pix_row = 0
- pix_col = 0
- frame_count = 0
REQ-031 A frame in flight when reset is applied SHALL be discarded; no further pixels of it SHALL be emitted.
REQ-032 frame_valid sampled during the reset cycle SHALL NOT be captured.

Verification
REQ-033 Basic stream: OH=2, OW=3, frame pixels 1..6, pix_ready=1 -> pixels 1,2,3,4,5,6 on 6 consecutive cycles; row/col sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); pix_last=1 only on 6; frame_count=1.
REQ-034 Backpressure: defaults, pix_ready toggling 1,0,0,1 -> pixel held stable during the low cycles; all 784 pixels delivered in order; none duplicated or dropped.
REQ-035 Frame isolation: frame changed to all 16'hFFFF after capture -> streamed values still equal the captured frame; frame_valid ignored until the last transfer.
REQ-036 Back-to-back frames: frame_valid held 1 across the final transfer -> a one-cycle IDLE gap, then the second frame starts at (0,0); frame_count goes 1 then 2.
REQ-037 Reset mid-stream: reset=0 after 100 transfers -> next cycle pix_valid=0, frame_ready=1, frame_count=0, row=col=0.
REQ-038 Wrap: 256 frames with OH=OW=1 -> frame_count returns to 0; every pixel carries pix_last=1.
